// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchronizer plus a history flop for one asynchronous SPI pin.
// Outputs the synced level and single-cycle rise/fall strobes in the clock domain.
module sync_edge #(
    parameter logic INIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta_r;
    logic sync_r;
    logic hist_r;

    // Capture chain; resets to the pin's idle level so reset release creates no edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= INIT;
            sync_r <= INIT;
            hist_r <= INIT;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            hist_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~hist_r;
    assign fall  = ~sync_r & hist_r;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, W-bit words, with pins oversampled in the clock domain.
// Transmit words are pulled from an in/get/empty source; received words are pushed via out/put.
module spi_slave #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic         get,
    input  logic         empty,
    output logic [W-1:0] out,
    output logic         put,
    output logic         underrun,
    input  logic         spi_cs_n,
    input  logic         spi_clock,
    input  logic         spi_mosi,
    output logic         spi_miso,
    output logic         spi_miso_en
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t        state_r;
    logic [W-1:0]  tx_shift_r;
    logic [W-1:0]  rx_shift_r;
    logic [W-1:0]  load_word_s;
    logic [CW-1:0] cnt_r;
    logic          reload_r;
    logic [1:0]    settle_r;
    logic          armed_r;

    logic cs_level_s, cs_rise_s, cs_fall_s;
    logic sck_level_unused_s, sck_rise_s, sck_fall_s;
    logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

    sync_edge #(.INIT(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .d(spi_cs_n),
        .level(cs_level_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    sync_edge #(.INIT(1'b0)) u_sync_sck (
        .clock(clock), .reset(reset), .d(spi_clock),
        .level(sck_level_unused_s), .rise(sck_rise_s), .fall(sck_fall_s)
    );

    sync_edge #(.INIT(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .d(spi_mosi),
        .level(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
    );

    // Word to load next: the source word, or all-ones when the source is empty.
    always_comb begin
        if (empty) begin
            load_word_s = {W{1'b1}};
        end else begin
            load_word_s = in;
        end
    end

    // Frame arming: the synchronizer starts at cs_n=1, so a CS already low at reset
    // release would look like a fresh fall; only arm once the chain has flushed and shows CS high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            settle_r <= 2'd0;
            armed_r  <= 1'b0;
        end else begin
            if (settle_r != 2'd3) begin
                settle_r <= settle_r + 2'd1;
            end
            armed_r <= armed_r | ((settle_r == 2'd3) & cs_level_s);
        end
    end

    // Frame FSM with shift registers and registered handshake/pad outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            tx_shift_r  <= {W{1'b0}};
            rx_shift_r  <= {W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            reload_r    <= 1'b0;
            get         <= 1'b0;
            put         <= 1'b0;
            underrun    <= 1'b0;
            out         <= {W{1'b0}};
            spi_miso    <= 1'b0;
            spi_miso_en <= 1'b0;
        end else begin
            get      <= 1'b0;
            put      <= 1'b0;
            underrun <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r    <= {CW{1'b0}};
                    reload_r <= 1'b0;
                    if (cs_fall_s && armed_r) begin
                        state_r     <= ACTIVE;
                        spi_miso_en <= 1'b1;
                        tx_shift_r  <= load_word_s;
                        spi_miso    <= load_word_s[W-1];
                        get         <= ~empty;
                        underrun    <= empty;
                    end else begin
                        spi_miso_en <= 1'b0;
                        spi_miso    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // CS release takes priority over a coincident SCK edge.
                    if (cs_rise_s) begin
                        state_r     <= IDLE;
                        cnt_r       <= {CW{1'b0}};
                        reload_r    <= 1'b0;
                        rx_shift_r  <= {W{1'b0}};
                        spi_miso_en <= 1'b0;
                        spi_miso    <= 1'b0;
                    end else if (sck_rise_s) begin
                        rx_shift_r <= {rx_shift_r[W-2:0], mosi_s};
                        if (cnt_r == LAST_BIT) begin
                            out      <= {rx_shift_r[W-2:0], mosi_s};
                            put      <= 1'b1;
                            cnt_r    <= {CW{1'b0}};
                            reload_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end else if (sck_fall_s) begin
                        if (reload_r) begin
                            reload_r   <= 1'b0;
                            tx_shift_r <= load_word_s;
                            spi_miso   <= load_word_s[W-1];
                            get        <= ~empty;
                            underrun   <= empty;
                        end else begin
                            tx_shift_r <= {tx_shift_r[W-2:0], 1'b0};
                            spi_miso   <= tx_shift_r[W-2];
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    spi_miso_en <= 1'b0;
                    spi_miso    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-level SPI master, queue-backed word source and a word-level
// reference model that predicts miso words, put words and get/underrun counts per frame.
module tb_spi_slave;
    localparam int W    = 8;
    localparam int HALF = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] src_in = 8'h00;
    logic         src_empty = 1'b1;
    logic         get;
    logic [W-1:0] out;
    logic         put;
    logic         underrun;
    logic         spi_cs_n;
    logic         spi_clock;
    logic         spi_mosi;
    logic         spi_miso;
    logic         spi_miso_en;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int get_cnt = 0, put_cnt = 0, und_cnt = 0, both_cnt = 0;
    int last_put_cyc = 0, rise_cyc = 0, en_bad = 0;
    logic [W-1:0] src_q[$];
    logic [W-1:0] put_q[$];
    logic [W-1:0] mo_w[4];
    logic [W-1:0] mi_w[4];

    spi_slave #(.W(W)) dut (
        .clock(clock), .reset(reset), .in(src_in), .get(get), .empty(src_empty),
        .out(out), .put(put), .underrun(underrun),
        .spi_cs_n(spi_cs_n), .spi_clock(spi_clock), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_en(spi_miso_en)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Source/sink side: pop consumed words, record pulses and received words.
    always @(negedge clock) begin
        if (get) begin
            get_cnt++;
            if (src_q.size() > 0) void'(src_q.pop_front());
        end
        if (underrun) und_cnt++;
        if (get && underrun) both_cnt++;
        if (put) begin
            put_cnt++;
            put_q.push_back(out);
            last_put_cyc = cyc;
        end
        src_empty = (src_q.size() == 0);
        src_in    = src_empty ? 8'h00 : src_q[0];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Mode-0 master: drive mosi before each rise, sample miso at the rise.
    task automatic run_frame(input int nbits);
        spi_cs_n = 1'b0;
        wait_clk(HALF);
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = mo_w[b/8][7 - (b % 8)];
            wait_clk(HALF);
            spi_clock = 1'b1;
            rise_cyc = cyc;
            mi_w[b/8][7 - (b % 8)] = spi_miso;
            if (spi_miso_en !== 1'b1) en_bad++;
            wait_clk(HALF);
            spi_clock = 1'b0;
        end
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    // Word-level model: one load at CS fall plus one after every completed word.
    task automatic do_frame(input int nbits, input string tag);
        logic [W-1:0] model[$];
        logic [W-1:0] exp_miso[4];
        logic [W-1:0] out0;
        int nfull, e_get, e_und, g0, u0, p0, pq0;
        model = src_q;
        nfull = nbits / 8;
        e_get = 0;
        e_und = 0;
        for (int l = 0; l <= nfull; l++) begin
            logic [W-1:0] w;
            if (model.size() > 0) begin
                w = model.pop_front();
                e_get++;
            end else begin
                w = 8'hFF;
                e_und++;
            end
            exp_miso[l] = w;
        end
        g0 = get_cnt; u0 = und_cnt; p0 = put_cnt; pq0 = put_q.size();
        out0 = out;
        en_bad = 0;
        run_frame(nbits);
        wait_clk(4);
        for (int i = 0; i < nfull; i++) begin
            check_eq({tag, "_miso"}, mi_w[i], exp_miso[i]);
            if (put_q.size() > pq0 + i) check_eq({tag, "_put_word"}, put_q[pq0 + i], mo_w[i]);
        end
        check_eq({tag, "_gets"}, get_cnt - g0, e_get);
        check_eq({tag, "_underruns"}, und_cnt - u0, e_und);
        check_eq({tag, "_puts"}, put_cnt - p0, nfull);
        check_eq({tag, "_out"}, out, (nfull > 0) ? mo_w[nfull-1] : out0);
        check_eq({tag, "_miso_en_frame"}, en_bad, 0);
        check_eq({tag, "_miso_en_idle"}, spi_miso_en, 1'b0);
        check_eq({tag, "_get_und_overlap"}, both_cnt, 0);
    endtask

    initial begin
        int g0, p0, u0;
        reset = 1'b1;
        spi_cs_n = 1'b1;
        spi_clock = 1'b0;
        spi_mosi = 1'b0;
        wait_clk(3);
        check_eq("rst_get", get, 1'b0);
        check_eq("rst_put", put, 1'b0);
        check_eq("rst_underrun", underrun, 1'b0);
        check_eq("rst_out", out, 8'h00);
        check_eq("rst_miso", spi_miso, 1'b0);
        check_eq("rst_miso_en", spi_miso_en, 1'b0);
        reset = 1'b0;
        wait_clk(10);

        // Single frame and put latency after the 8th rise.
        src_q.push_back(8'hA5);
        mo_w[0] = 8'h3C;
        do_frame(8, "t1");
        check_eq("t1_put_latency", ((last_put_cyc - rise_cyc) >= 3) && ((last_put_cyc - rise_cyc) <= 4), 1'b1);

        // Back-to-back words with CS held low.
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        mo_w[0] = 8'hF0;
        mo_w[1] = 8'h0F;
        do_frame(16, "t2");

        // Underrun: source empty at CS fall.
        mo_w[0] = W'($urandom);
        do_frame(8, "t3");

        // Abort after 5 edges, then a clean frame.
        mo_w[0] = W'($urandom);
        do_frame(5, "t4");
        src_q.push_back(8'h5A);
        mo_w[0] = 8'hC3;
        do_frame(8, "t4b");

        // SCK toggling while deselected.
        g0 = get_cnt; p0 = put_cnt; u0 = und_cnt; en_bad = 0;
        for (int i = 0; i < 10; i++) begin
            spi_clock = ~spi_clock;
            wait_clk(HALF);
            if (spi_miso_en !== 1'b0) en_bad++;
        end
        check_eq("t6_gets", get_cnt - g0, 0);
        check_eq("t6_puts", put_cnt - p0, 0);
        check_eq("t6_underruns", und_cnt - u0, 0);
        check_eq("t6_miso_en", en_bad, 0);

        // Asynchronous reset mid-frame, CS left low afterwards.
        src_q.push_back(8'h77);
        spi_cs_n = 1'b0;
        wait_clk(HALF);
        for (int b = 0; b < 3; b++) begin
            spi_mosi = 1'($urandom);
            wait_clk(HALF);
            spi_clock = 1'b1;
            wait_clk(HALF);
            spi_clock = 1'b0;
        end
        #3 reset = 1'b1;
        #1;
        check_eq("t5_rst_get", get, 1'b0);
        check_eq("t5_rst_put", put, 1'b0);
        check_eq("t5_rst_underrun", underrun, 1'b0);
        check_eq("t5_rst_out", out, 8'h00);
        check_eq("t5_rst_miso", spi_miso, 1'b0);
        check_eq("t5_rst_miso_en", spi_miso_en, 1'b0);
        wait_clk(2);
        reset = 1'b0;
        g0 = get_cnt; p0 = put_cnt; u0 = und_cnt; en_bad = 0;
        for (int b = 0; b < 8; b++) begin
            spi_mosi = 1'($urandom);
            wait_clk(HALF);
            spi_clock = 1'b1;
            if (spi_miso_en !== 1'b0) en_bad++;
            wait_clk(HALF);
            spi_clock = 1'b0;
        end
        check_eq("t5_held_gets", get_cnt - g0, 0);
        check_eq("t5_held_puts", put_cnt - p0, 0);
        check_eq("t5_held_underruns", und_cnt - u0, 0);
        check_eq("t5_held_miso_en", en_bad, 0);
        spi_cs_n = 1'b1;
        wait_clk(HALF);
        src_q.push_back(8'h96);
        mo_w[0] = 8'h69;
        do_frame(8, "t5b");

        // Randomized frames: word count, partial tails and source fill level.
        for (int f = 0; f < 8; f++) begin
            int nw, extra, fill;
            nw    = $urandom_range(1, 3);
            extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            fill  = $urandom_range(0, 4);
            for (int k = 0; k < fill; k++) src_q.push_back(W'($urandom));
            for (int k = 0; k < 4; k++) mo_w[k] = W'($urandom);
            wait_clk(2);
            do_frame(nw * 8 + extra, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
